regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor of the core's integer register file.
- Features: generic width/depth, configurable read-port count, same-cycle write-to-read bypass, hardware zero-clear sequence after reset, per-register pending scoreboard for the decode/hazard stage.
- Sits between decode (reads, issue) and writeback (write port).
- Ready flag tells the front end when it may start issuing.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of 2, ≥2).
- NRD, 2, number of read ports.
- AW, $clog2(NREGS), register index width (derived; not overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high once the clear sequence has finished.
- rs  in  NRD*AW  packed read indices; port i = bits [i*AW +: AW].
- rdata  out  NRD*XLEN  packed read data, combinational.
- rs_pending  out  NRD  per-port pending flag, combinational.
- we  in  1  writeback write enable.
- rd  in  AW  writeback index.
- wdata  in  XLEN  writeback data.
- issue_valid  in  1  an instruction with a destination issues this cycle.
- issue_rd  in  AW  destination index of the issuing instruction.

Behaviour:
- Reset:
  - rst high at an edge → state CLEAR, clear_idx=0, pending vector all 0, ready=0.
  - rst during CLEAR restarts at index 0.
  - rst during RUN aborts and re-enters CLEAR.
- FSM states:
  - CLEAR: each cycle writes 0 to regs[clear_idx], then clear_idx++. After writing index NREGS-1 → RUN. CLEAR lasts exactly NREGS cycles after rst deasserts; ready rises on the following cycle.
  - RUN: ready=1; stays here until rst.
- In CLEAR:
  - we and issue_valid are ignored (no write, no pending update).
  - rdata = 0 and rs_pending = 0 on every port.
- Index 0 (x0):
  - reads always 0.
  - writes ignored.
  - never pending (issue_rd=0 ignored).
- Write: in RUN, if we && rd≠0, regs[rd] ← wdata at the edge.
- Read (combinational, port i):
  - rs_i==0 → 0.
  - else if RUN && we && rd==rs_i → wdata (bypass).
  - else regs[rs_i].
  - No read latency.
- Scoreboard (RUN only):
  - issue_valid && issue_rd≠0 sets pending[issue_rd] at the edge.
  - we && rd≠0 clears pending[rd] at the edge.
  - Issue and write to the same index in the same cycle: set wins. The write belongs to an older producer.
- rs_pending[i] = pending[rs_i] & ~(we && rd==rs_i && rd≠0). It is consistent with the bypass, so a consumer reading a register being written this cycle sees valid data, not a hazard.
- Multiple read ports on the same index return identical data and flags.
- Widths: no arithmetic beyond clear_idx. clear_idx is AW+1 bits so the terminal compare does not wrap.

Decomposition:
- Package regfile_pkg:
  - XLEN/NREGS defaults.
  - reg_idx_t (logic [AW-1:0]).
  - rf_state_e {RF_CLEAR, RF_RUN}.
- Sub-module regfile_scoreboard holds the pending vector, the set/clear priority logic and the pending-output masking.
- Storage, clear FSM and bypass muxes stay in regfile_sb.

Test Plan:
- Clear sequence: fill every register, pulse rst 1 cycle → ready low exactly 32 cycles, then high; every index reads 0; rs_pending all 0.
- Reset mid-clear: assert rst at clear cycle 10 → counter restarts; ready rises 32 cycles after the second rst deasserts.
- Write/read and x0: write rd=5 wdata=0xDEADBEEF → next cycle rs[0]=5 returns 0xDEADBEEF. Write rd=0 0x1234 → rs=0 reads 0.
- Bypass: same cycle we=1 rd=7 wdata=0xA5A5A5A5 with rs[0]=7, rs[1]=7 → both ports return 0xA5A5A5A5 combinationally; regs[7] updated after the edge.
- Scoreboard: issue rd=3 → next cycle rs_pending for index 3 = 1. Write rd=3 → rs_pending=0 in that cycle (masked) and after the edge. Simultaneous issue rd=3 and write rd=3 → pending stays 1.
- Ignored in CLEAR: we=1 rd=4 wdata=0xFF and issue rd=4 during CLEAR → after ready, reg 4 reads 0 and pending[4]=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the integer register file with scoreboard.
package regfile_pkg;
  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_AW    = $clog2(RF_NREGS);

  typedef logic [RF_AW-1:0] reg_idx_t;

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for hazard detection; issue sets, writeback clears.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               we,
  input  logic [AW-1:0]      rd,
  input  logic               issue_valid,
  input  logic [AW-1:0]      issue_rd,
  input  logic [NRD*AW-1:0]  rs,
  output logic [NRD-1:0]     rs_pending
);
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic             wr_clr;

  assign wr_clr = we && (rd != '0);

  // Set is applied after clear: the write belongs to an older producer.
  always_comb begin
    pending_nxt = pending;
    if (run && wr_clr)
      pending_nxt[rd] = 1'b0;
    if (run && issue_valid && (issue_rd != '0))
      pending_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [AW-1:0] idx;
    assign idx = rs[i*AW +: AW];
    // Masked in step with the bypass so a same-cycle writeback is not a hazard.
    assign rs_pending[i] = run && pending[idx] && !(wr_clr && (rd == idx));
  end
endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file: zero-clear after reset, write-to-read bypass, pending scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = RF_XLEN,
  parameter  int NREGS = RF_NREGS,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic [NRD*AW-1:0]    rs,
  output logic [NRD*XLEN-1:0]  rdata,
  output logic [NRD-1:0]       rs_pending,
  input  logic                 we,
  input  logic [AW-1:0]        rd,
  input  logic [XLEN-1:0]      wdata,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd
);
  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS-1);

  rf_state_e       state;
  logic [AW:0]     clear_idx;
  logic [XLEN-1:0] regs [NREGS];
  logic            run;

  assign run = (state == RF_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RF_CLEAR;
      clear_idx <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        RF_CLEAR: begin
          clear_idx <= clear_idx + (AW+1)'(1);
          if (clear_idx == LAST_IDX) begin
            state <= RF_RUN;
            ready <= 1'b1;
          end
        end
        RF_RUN:  ready <= 1'b1;
        default: state <= RF_CLEAR;
      endcase
    end
  end

  // Storage has no reset of its own; the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == RF_CLEAR)
        regs[clear_idx[AW-1:0]] <= '0;
      else if (we && (rd != '0))
        regs[rd] <= wdata;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx = rs[i*AW +: AW];
    assign rdata[i*XLEN +: XLEN] =
      (!run || (idx == '0)) ? '0    :
      (we && (rd == idx))   ? wdata :
                              regs[idx];
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .we          (we),
    .rd          (rd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs          (rs),
    .rs_pending  (rs_pending)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb against an array/counter reference model.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = $clog2(NREGS);

  logic                clk = 1'b0;
  logic                rst;
  logic                ready;
  logic [NRD*AW-1:0]   rs;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rs_pending;
  logic                we;
  logic [AW-1:0]       rd;
  logic [XLEN-1:0]     wdata;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] mregs [NREGS];
  bit              mpend [NREGS];
  bit              mrun;
  int              clr_left;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .ready(ready), .rs(rs), .rdata(rdata),
    .rs_pending(rs_pending), .we(we), .rd(rd), .wdata(wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] exp_rdata(input logic [AW-1:0] idx);
    if (!mrun || idx == 0) return '0;
    if (we && rd == idx)   return wdata;
    return mregs[idx];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] idx);
    if (!mrun || idx == 0) return 1'b0;
    if (we && rd == idx)   return 1'b0;
    return mpend[idx];
  endfunction

  // Advance model by one clock using the current inputs, then step the DUT.
  task automatic tick();
    if (rst) begin
      mrun = 0; clr_left = NREGS;
      for (int i = 0; i < NREGS; i++) begin mregs[i] = '0; mpend[i] = 0; end
    end else if (!mrun) begin
      clr_left--;
      if (clr_left == 0) mrun = 1;
    end else begin
      if (we && rd != 0) begin mregs[rd] = wdata; mpend[rd] = 0; end
      if (issue_valid && issue_rd != 0) mpend[issue_rd] = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    we = 0; rd = '0; wdata = '0; issue_valid = 0; issue_rd = '0;
  endtask

  task automatic test_reset();
    int n;
    idle(); rs = '0;
    rst = 1; tick(); tick();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    rst = 0; n = 0;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n != NREGS) begin errors++; $display("FAIL initial_clear_len got %0d want %0d", n, NREGS); end
    for (int i = 1; i < NREGS; i++) begin
      we = 1; rd = AW'(i); wdata = $urandom; tick();
    end
    idle();
    rst = 1; tick(); rst = 0; n = 0;
    while (ready !== 1'b1 && n < 100) begin
      checks++;
      if (ready !== mrun) begin errors++; $display("FAIL clear_ready cyc %0d got %b want %b", n, ready, mrun); end
      tick(); n++;
    end
    checks++;
    if (n != NREGS) begin errors++; $display("FAIL clear_len got %0d want %0d", n, NREGS); end
    for (int i = 0; i < NREGS; i++) begin
      rs[0 +: AW] = AW'(i); rs[AW +: AW] = AW'(NREGS-1-i); #1;
      checks++;
      if (rdata !== '0 || rs_pending !== '0) begin
        errors++; $display("FAIL cleared_read idx %0d got %h/%b want 0/0", i, rdata, rs_pending);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    idle();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1; tick(); rst = 0; n = 0;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n != NREGS) begin errors++; $display("FAIL midclear_len got %0d want %0d", n, NREGS); end
  endtask

  task automatic test_write_read();
    we = 1; rd = 5; wdata = 32'hDEADBEEF; tick(); idle();
    rs[0 +: AW] = 5; #1;
    checks++;
    if (rdata[0 +: XLEN] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_read got %h want deadbeef", rdata[0 +: XLEN]);
    end
    we = 1; rd = 0; wdata = 32'h1234; rs[0 +: AW] = 0; #1;
    checks++;
    if (rdata[0 +: XLEN] !== '0) begin errors++; $display("FAIL x0_bypass got %h want 0", rdata[0 +: XLEN]); end
    tick(); idle(); #1;
    checks++;
    if (rdata[0 +: XLEN] !== '0) begin errors++; $display("FAIL x0_write got %h want 0", rdata[0 +: XLEN]); end
  endtask

  task automatic test_bypass();
    we = 1; rd = 7; wdata = 32'hA5A5A5A5; rs[0 +: AW] = 7; rs[AW +: AW] = 7; #1;
    checks++;
    if (rdata !== {2{32'hA5A5A5A5}}) begin errors++; $display("FAIL bypass got %h want a5a5a5a5 x2", rdata); end
    tick(); idle(); #1;
    checks++;
    if (rdata !== {2{32'hA5A5A5A5}}) begin errors++; $display("FAIL bypass_stored got %h want a5a5a5a5 x2", rdata); end
  endtask

  task automatic test_scoreboard();
    rs[0 +: AW] = 3; rs[AW +: AW] = 3;
    issue_valid = 1; issue_rd = 3; tick(); idle(); #1;
    checks++;
    if (rs_pending !== 2'b11) begin errors++; $display("FAIL sb_set got %b want 11", rs_pending); end
    we = 1; rd = 3; wdata = 32'h0BAD_F00D; #1;
    checks++;
    if (rs_pending !== 2'b00) begin errors++; $display("FAIL sb_mask got %b want 00", rs_pending); end
    tick(); idle(); #1;
    checks++;
    if (rs_pending !== 2'b00) begin errors++; $display("FAIL sb_clear got %b want 00", rs_pending); end
    issue_valid = 1; issue_rd = 3; tick(); idle();
    issue_valid = 1; issue_rd = 3; we = 1; rd = 3; wdata = 32'h1111_2222; tick(); idle(); #1;
    checks++;
    if (rs_pending !== 2'b11) begin errors++; $display("FAIL sb_set_wins got %b want 11", rs_pending); end
    issue_valid = 1; issue_rd = 0; tick(); idle();
    rs[0 +: AW] = 0; #1;
    checks++;
    if (rs_pending[0] !== 1'b0) begin errors++; $display("FAIL sb_x0 got %b want 0", rs_pending[0]); end
    we = 1; rd = 3; wdata = '0; tick(); idle();
  endtask

  task automatic test_ignored_in_clear();
    int n;
    rst = 1; tick(); rst = 0;
    rs[0 +: AW] = 4; rs[AW +: AW] = 4;
    for (int i = 0; i < 8; i++) begin
      we = 1; rd = 4; wdata = 32'hFF; issue_valid = 1; issue_rd = 4; #1;
      checks++;
      if (rdata !== '0 || rs_pending !== '0) begin
        errors++; $display("FAIL clear_outputs got %h/%b want 0/0", rdata, rs_pending);
      end
      tick();
    end
    idle(); n = 0;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    #1;
    checks++;
    if (rdata !== '0 || rs_pending !== '0 || ready !== 1'b1) begin
      errors++; $display("FAIL clear_ignored got %h/%b rdy %b want 0/0 rdy 1", rdata, rs_pending, ready);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      we          = $urandom_range(0, 1);
      rd          = AW'($urandom_range(0, 7));
      wdata       = $urandom;
      issue_valid = $urandom_range(0, 1);
      issue_rd    = AW'($urandom_range(0, 7));
      for (int p = 0; p < NRD; p++) rs[p*AW +: AW] = AW'($urandom_range(0, 7));
      #1;
      checks++;
      if (ready !== mrun) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, ready, mrun); end
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (rdata[p*XLEN +: XLEN] !== exp_rdata(rs[p*AW +: AW]) ||
            rs_pending[p] !== exp_pend(rs[p*AW +: AW])) begin
          errors++;
          $display("FAIL rnd_read cyc %0d port %0d idx %0d got %h/%b want %h/%b", c, p,
                   rs[p*AW +: AW], rdata[p*XLEN +: XLEN], rs_pending[p],
                   exp_rdata(rs[p*AW +: AW]), exp_pend(rs[p*AW +: AW]));
        end
      end
      tick();
    end
    rst = 0; idle();
  endtask

  initial begin
    mrun = 0; clr_left = NREGS;
    for (int i = 0; i < NREGS; i++) begin mregs[i] = '0; mpend[i] = 0; end
    rst = 1; rs = '0; idle();
    #1;
    test_reset();
    test_reset_mid_clear();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_ignored_in_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
